// File: rtl/qwac_pkg.sv
// Shared widths, element/vector types and the serializer state type for the vector datapath.
package qwac_pkg;

  localparam int unsigned ElemBits = 8;
  localparam int unsigned VecElems = 4;

  typedef logic signed [ElemBits-1:0] elem_t;
  typedef logic [VecElems-1:0][ElemBits-1:0] vec_t;

  typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;

endpackage

// File: rtl/vec_serialize.sv
// Vector-to-stream converter: captures one signed vector on a valid/ready handshake and
// replays it one element per beat, index 0 first, with index and last flag.
module vec_serialize
  import qwac_pkg::*;
#(
  parameter int unsigned BITS    = ElemBits,
  parameter int unsigned VEC_LEN = VecElems,
  localparam int unsigned IDX_W  = $clog2(VEC_LEN)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [VEC_LEN-1:0][BITS-1:0]  in_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BITS-1:0]               out_elem,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic                          busy
);

  if (VEC_LEN < 2) begin : g_bad_vec_len
    $error("vec_serialize: VEC_LEN must be >= 2");
  end

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(VEC_LEN - 1);

  ser_state_t                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [VEC_LEN-1:0][BITS-1:0] buf_q, buf_d;
  logic                        load;

  always_comb begin
    out_valid = (state_q == SER_SEND);
    out_last  = out_valid && (idx_q == LastIdx);
    out_idx   = idx_q;
    busy      = out_valid;
    // Gate the mux so an idle block shows zero rather than a stale element.
    out_elem  = out_valid ? buf_q[idx_q] : '0;
    // out_ready -> in_ready is the only combinational path through the block.
    in_ready  = (state_q == SER_IDLE) || (out_last && out_ready);
    load      = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    if (load) begin
      buf_d   = in_vec;
      idx_d   = '0;
      state_d = SER_SEND;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        idx_d   = '0;
        state_d = SER_IDLE;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SER_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

endmodule
